rfmem_sys: RTL

- Memory subsystem directly downstream of the register-file core wrapper; consumes its mem_read/mem_wren/mem_addr/mem_size/memwrite_data port and produces memread_data.
- Contains a byte-lane word RAM, an MMIO window with a console TX FIFO (valid/ready to host), sticky status flags and an optional cycle counter.
- Reads are combinational, for single-cycle compatibility with the core. Writes commit on the clock edge.

---
 rtl/rfmem_sys.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/rfmem_sys.sv
// rtl/rfmem_sys.sv - word RAM with byte lanes plus MMIO console FIFO, status and cycle counter
//
// Memory subsystem behind the register-file core. Loads are combinational and
// stores commit on the clock edge, so the core sees single-cycle memory.
//
// Optional feature macro: RFMEM_CYCLECNT_EN (free-running cycle counter at +8).
//
// Ports:
//   clk           clock
//   rst           synchronous active-low reset
//   mem_read      load request this cycle
//   mem_wren      store request this cycle (wins over mem_read)
//   mem_addr      byte address
//   mem_size      0=byte, 1=half, 2/3=word
//   memwrite_data store data, right-justified
//   memread_data  load data, right-justified, zero-extended
//   tx_valid      console FIFO head valid
//   tx_data       console FIFO head byte
//   tx_ready      host accepts the head byte
//   err_irq       registered OR of sticky OVF and MIS
module rfmem_sys #(
  parameter int          MEMWORDS  = 4096,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
  parameter int          TXDEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_wren,
  input  logic [31:0] mem_addr,
  input  logic [1:0]  mem_size,
  input  logic [31:0] memwrite_data,
  output logic [31:0] memread_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        err_irq
);

  localparam int WIDX = $clog2(MEMWORDS);
  localparam int PW   = $clog2(TXDEPTH);
  localparam int CW   = PW + 1;

  // ---------------------------------------------------------------- decode
  logic size_half;
  logic size_word;
  logic misaligned;
  logic is_mmio;
  logic mmio_bad;
  logic mmio_ok;
  logic mis_evt;
  logic ram_we;

  assign size_word  = mem_size[1];
  assign size_half  = (mem_size == 2'd1);
  assign misaligned = (size_half && mem_addr[0]) ||
                      (size_word && (mem_addr[1:0] != 2'b00));
  assign is_mmio    = (mem_addr[31:4] == MMIO_BASE[31:4]);
  // MMIO registers only accept word accesses; narrower ones count as misaligned.
  assign mmio_bad   = is_mmio && !size_word;
  assign mmio_ok    = is_mmio && size_word && !misaligned;
  assign mis_evt    = (mem_read || mem_wren) && (misaligned || mmio_bad);
  assign ram_we     = mem_wren && !is_mmio && !misaligned;

  // ------------------------------------------------------------------- RAM
  logic [31:0]     ram [MEMWORDS];
  logic [WIDX-1:0] widx;
  logic [31:0]     ram_word;
  logic [31:0]     ram_shift;
  logic [31:0]     ram_rd;
  logic [3:0]      be;
  logic [31:0]     wdata;

  // Upper address bits are ignored, so RAM aliases across the address space.
  assign widx      = mem_addr[WIDX+1:2];
  assign ram_word  = ram[widx];
  assign ram_shift = ram_word >> {mem_addr[1:0], 3'b000};

  always_comb begin
    ram_rd = {24'h0, ram_shift[7:0]};
    if (size_word) begin
      ram_rd = ram_shift;
    end else if (size_half) begin
      ram_rd = {16'h0, ram_shift[15:0]};
    end
  end

  // Low bytes of the store data are replicated across lanes; the byte
  // enables pick which lanes actually change.
  always_comb begin
    be    = 4'b0001 << mem_addr[1:0];
    wdata = {4{memwrite_data[7:0]}};
    if (size_word) begin
      be    = 4'b1111;
      wdata = memwrite_data;
    end else if (size_half) begin
      be    = mem_addr[1] ? 4'b1100 : 4'b0011;
      wdata = {2{memwrite_data[15:0]}};
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          ram[widx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // --------------------------------------------------------------- TX FIFO
  logic [7:0]    fifo [TXDEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          push_req;
  logic          push_ok;
  logic          pop;
  logic          ovf_evt;

  assign empty    = (count == '0);
  assign full     = (count == CW'(TXDEPTH));
  assign push_req = mem_wren && mmio_ok && (mem_addr[3:2] == 2'd0);
  assign pop      = !empty && tx_ready;
  // A pop frees the slot in the same edge, so a push into a full FIFO that is
  // draining still lands.
  assign push_ok  = push_req && (!full || pop);
  assign ovf_evt  = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        fifo[wr_ptr] <= memwrite_data[7:0];
        wr_ptr       <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push_ok) - CW'(pop);
    end
  end

  assign tx_valid = !empty;
  assign tx_data  = empty ? 8'h00 : fifo[rd_ptr];

  // ---------------------------------------------------------- status flags
  logic ovf_q;
  logic mis_q;
  logic status_wr;

  assign status_wr = mem_wren && mmio_ok && (mem_addr[3:2] == 2'd1);

  // Set events take priority over a write-one-to-clear in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_q   <= 1'b0;
      mis_q   <= 1'b0;
      err_irq <= 1'b0;
    end else begin
      ovf_q   <= ovf_evt || (ovf_q && !(status_wr && memwrite_data[2]));
      mis_q   <= mis_evt || (mis_q && !(status_wr && memwrite_data[3]));
      err_irq <= ovf_q || mis_q;
    end
  end

  // --------------------------------------------------------- cycle counter
  logic [31:0] cycle_val;

`ifdef RFMEM_CYCLECNT_EN
  logic [31:0] cycle_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_q <= 32'h0;
    end else begin
      cycle_q <= cycle_q + 32'h1;
    end
  end

  assign cycle_val = cycle_q;
`else
  assign cycle_val = 32'h0;
`endif

  // ------------------------------------------------------------ read mux
  logic [31:0] mmio_rd;

  always_comb begin
    mmio_rd = 32'h0;
    case (mem_addr[3:2])
      2'd1:    mmio_rd = {28'h0, mis_q, ovf_q, empty, full};
      2'd2:    mmio_rd = cycle_val;
      default: mmio_rd = 32'h0;
    endcase
  end

  always_comb begin
    memread_data = 32'h0;
    if (mem_read && !misaligned && !mmio_bad) begin
      memread_data = is_mmio ? mmio_rd : ram_rd;
    end
  end

endmodule
